vga_scan_gen: RTL and testbench

- Pixel-timing stage directly upstream and downstream of the display controller.
- Divides the system clock to a pixel tick and runs the horizontal and vertical scan counters. These drive scan_x/scan_y into the display controller.
- Registers the controller's 12-bit colour, blanks it outside the visible region, and drives the VGA connector pins: RGB, hs and vs, all time-aligned.

---
 rtl/vga_scan_gen_if.sv | 27 ++
 rtl/vga_scan_gen.sv | 120 ++++++++++++
 tb/tb_vga_scan_gen.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/vga_scan_gen_if.sv
// Signal bundle between the scan generator, the display controller and the VGA pins.
// master = scan generator (drives scan position and pins), slave = controller side.
interface vga_scan_gen_if;
    logic [11:0] rgb_in;
    logic [9:0]  scan_x;
    logic [9:0]  scan_y;
    logic        pix_tick;
    logic        video_on;
    logic        frame_start;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        hs;
    logic        vs;

    modport master (
        input  rgb_in,
        output scan_x, scan_y, pix_tick, video_on, frame_start,
        output vga_r, vga_g, vga_b, hs, vs
    );

    modport slave (
        output rgb_in,
        input  scan_x, scan_y, pix_tick, video_on, frame_start,
        input  vga_r, vga_g, vga_b, hs, vs
    );
endinterface

// File: rtl/vga_scan_gen.sv
// VGA pixel divider, scan counters, sync generation and one-pixel output register stage.
// Optional VGA_BORDER_EN forces a white frame around the visible area.
module vga_scan_gen #(
    parameter int PIX_DIV = 4,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic           clk,
    input  logic           rst,
    vga_scan_gen_if.master vga
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             fs_q, fs_d;

    logic             pix_tick;
    logic             h_last;
    logic             v_last;
    logic             video_on;
    logic             hs_raw;
    logic             vs_raw;
    logic [11:0]      pix_col;

    assign pix_tick = (div_cnt_q == DIV_LAST);
    assign h_last   = (h_cnt_q == H_LAST);
    assign v_last   = (v_cnt_q == V_LAST);
    assign video_on = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    assign hs_raw   = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    assign vs_raw   = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));

`ifdef VGA_BORDER_EN
    localparam logic [9:0] H_EDGE = 10'(H_VIS - 1);
    localparam logic [9:0] V_EDGE = 10'(V_VIS - 1);
    logic on_border;
    assign on_border = (h_cnt_q == 10'd0) || (h_cnt_q == H_EDGE) ||
                       (v_cnt_q == 10'd0) || (v_cnt_q == V_EDGE);
    assign pix_col   = on_border ? 12'hFFF : vga.rgb_in;
`else
    assign pix_col   = vga.rgb_in;
`endif

    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        rgb_d     = rgb_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        fs_d      = 1'b0;
        if (pix_tick) begin
            div_cnt_d = '0;
            // Colour and sync sample the pre-increment position, so both lag scan_x/y by one pixel.
            rgb_d = video_on ? pix_col : 12'h000;
            hs_d  = hs_raw;
            vs_d  = vs_raw;
            if (h_last) begin
                h_cnt_d = 10'd0;
                v_cnt_d = v_last ? 10'd0 : v_cnt_q + 10'd1;
                fs_d    = v_last;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            h_cnt_q   <= 10'd0;
            v_cnt_q   <= 10'd0;
            rgb_q     <= 12'h000;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            fs_q      <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            rgb_q     <= rgb_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            fs_q      <= fs_d;
        end
    end

    assign vga.scan_x      = h_cnt_q;
    assign vga.scan_y      = v_cnt_q;
    assign vga.pix_tick    = pix_tick;
    assign vga.video_on    = video_on;
    assign vga.frame_start = fs_q;
    assign vga.vga_r       = rgb_q[11:8];
    assign vga.vga_g       = rgb_q[7:4];
    assign vga.vga_b       = rgb_q[3:0];
    assign vga.hs          = hs_q;
    assign vga.vs          = vs_q;
endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed-vector bench for vga_scan_gen on a shrunken 15x10 raster (8x6 visible) so full frames fit.
module tb_vga_scan_gen;
    // Raster: H 8+2+3+2 = 15, hs low for h in 10..12; V 6+1+2+1 = 10, vs low for v in 7..8.
    localparam int NV = 21;
`ifdef VGA_BORDER_EN
    localparam logic [11:0] RGB_IN     = 12'h000;
    localparam logic [11:0] BORDER_COL = 12'hFFF;
`else
    localparam logic [11:0] RGB_IN     = 12'hABC;
    localparam logic [11:0] BORDER_COL = 12'hABC;
`endif

    typedef struct {
        int         k;      // clk edges since reset release
        logic [9:0] x;
        logic [9:0] y;
        logic       tick;
        logic       von;
        logic [1:0] ck;     // 0 blank, 1 interior visible, 2 border visible
        logic       hs;
        logic       vs;
        logic       fs;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[NV];

    vga_scan_gen_if bus();

    vga_scan_gen #(
        .PIX_DIV(4), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vga(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] col_of(input logic [1:0] ck);
        case (ck)
            2'd1:    return RGB_IN;
            2'd2:    return BORDER_COL;
            default: return 12'h000;
        endcase
    endfunction

    task automatic chk(input string nm, input int k, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s k=%0d actual=%h required=%h", nm, k, act, exp);
        end
    endtask

    task automatic chk_vec(input vec_t v);
        chk("scan_x", v.k, {2'b0, bus.scan_x}, {2'b0, v.x});
        chk("scan_y", v.k, {2'b0, bus.scan_y}, {2'b0, v.y});
        chk("pix_tick", v.k, {11'b0, bus.pix_tick}, {11'b0, v.tick});
        chk("video_on", v.k, {11'b0, bus.video_on}, {11'b0, v.von});
        chk("rgb", v.k, {bus.vga_r, bus.vga_g, bus.vga_b}, col_of(v.ck));
        chk("hs", v.k, {11'b0, bus.hs}, {11'b0, v.hs});
        chk("vs", v.k, {11'b0, bus.vs}, {11'b0, v.vs});
        chk("frame_start", v.k, {11'b0, bus.frame_start}, {11'b0, v.fs});
    endtask

    initial begin
        int fs_cnt;
        int fs_k[$];
        int waited;
        bit found;

        //             k    x      y      tk von ck hs vs fs
        vecs[0]  = '{  0, 10'd0,  10'd0,  0, 1, 0, 1, 1, 0};
        vecs[1]  = '{  3, 10'd0,  10'd0,  1, 1, 0, 1, 1, 0};
        vecs[2]  = '{  4, 10'd1,  10'd0,  0, 1, 2, 1, 1, 0};
        vecs[3]  = '{ 32, 10'd8,  10'd0,  0, 0, 2, 1, 1, 0};
        vecs[4]  = '{ 36, 10'd9,  10'd0,  0, 0, 0, 1, 1, 0};
        vecs[5]  = '{ 40, 10'd10, 10'd0,  0, 0, 0, 1, 1, 0};
        vecs[6]  = '{ 44, 10'd11, 10'd0,  0, 0, 0, 0, 1, 0};
        vecs[7]  = '{ 52, 10'd13, 10'd0,  0, 0, 0, 0, 1, 0};
        vecs[8]  = '{ 56, 10'd14, 10'd0,  0, 0, 0, 1, 1, 0};
        vecs[9]  = '{ 60, 10'd0,  10'd1,  0, 1, 0, 1, 1, 0};
        vecs[10] = '{ 68, 10'd2,  10'd1,  0, 1, 1, 1, 1, 0};
        vecs[11] = '{268, 10'd7,  10'd4,  0, 1, 1, 1, 1, 0};
        vecs[12] = '{332, 10'd8,  10'd5,  0, 0, 2, 1, 1, 0};
        vecs[13] = '{364, 10'd1,  10'd6,  0, 0, 0, 1, 1, 0};
        vecs[14] = '{420, 10'd0,  10'd7,  0, 0, 0, 1, 1, 0};
        vecs[15] = '{424, 10'd1,  10'd7,  0, 0, 0, 1, 0, 0};
        vecs[16] = '{540, 10'd0,  10'd9,  0, 0, 0, 1, 0, 0};
        vecs[17] = '{544, 10'd1,  10'd9,  0, 0, 0, 1, 1, 0};
        vecs[18] = '{599, 10'd14, 10'd9,  1, 0, 0, 1, 1, 0};
        vecs[19] = '{600, 10'd0,  10'd0,  0, 1, 0, 1, 1, 1};
        vecs[20] = '{601, 10'd0,  10'd0,  0, 1, 0, 1, 1, 0};

        bus.rgb_in = RGB_IN;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Free run over two frames, sampling on every falling edge.
        fs_cnt = 0;
        for (int k = 0; k <= 1201; k++) begin
            for (int i = 0; i < NV; i++)
                if (vecs[i].k == k) chk_vec(vecs[i]);
            if (bus.frame_start === 1'b1) begin
                fs_cnt++;
                fs_k.push_back(k);
            end
            @(negedge clk);
        end
        chk("fs_count", 1201, 12'(fs_cnt), 12'd2);
        if (fs_k.size() == 2) begin
            chk("fs_first", fs_k[0], 12'(fs_k[0]), 12'd600);
            chk("fs_second", fs_k[1], 12'(fs_k[1]), 12'd1200);
        end

        // Mid-frame reset, landing on a pix_tick edge inside both sync pulses.
        found = 1'b0;
        waited = 0;
        while (!found && waited < 800) begin
            if (bus.pix_tick === 1'b1 && bus.scan_x === 10'd11 && bus.scan_y === 10'd7)
                found = 1'b1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        chk("rst_target_found", waited, {11'b0, found}, 12'd1);
        chk("pre_rst_hs", 0, {11'b0, bus.hs}, 12'd0);
        chk("pre_rst_vs", 0, {11'b0, bus.vs}, 12'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_vec('{0, 10'd0, 10'd0, 0, 1, 0, 1, 1, 0});
        fs_cnt = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (bus.frame_start === 1'b1) fs_cnt++;
        end
        chk_vec('{4, 10'd1, 10'd0, 0, 1, 2, 1, 1, 0});
        chk("rst_no_fs", 4, 12'(fs_cnt), 12'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
